// File: rtl/pam4_rx_checker.sv
// PAM-4 receiver: slices voltage samples to Gray-coded bit pairs and checks them
// against PRBS31 (x^31+x^28+1), tracking lock state plus bit and error counts.
module pam4_rx_checker #(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int LOCK_COUNT        = 64,
    parameter int WINDOW            = 128,
    parameter int UNLOCK_ERRS       = 16,
    parameter int COUNT_W           = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [SIGNAL_RESOLUTION-1:0] voltage_level_in,
    input  logic                         voltage_level_in_valid,
    input  logic                         clear_counts,
    output logic [1:0]                   symbol_out,
    output logic                         symbol_out_valid,
    output logic                         locked,
    output logic [1:0]                   error_out,
    output logic                         error_out_valid,
    output logic [COUNT_W-1:0]           bit_count,
    output logic [COUNT_W-1:0]           error_count
);
    localparam int MID_I = 2 ** (SIGNAL_RESOLUTION - 1);
    localparam logic [SIGNAL_RESOLUTION-1:0] TH_LO  = SIGNAL_RESOLUTION'(MID_I - SYMBOL_SEPERATION);
    localparam logic [SIGNAL_RESOLUTION-1:0] TH_MID = SIGNAL_RESOLUTION'(MID_I);
    localparam logic [SIGNAL_RESOLUTION-1:0] TH_HI  = SIGNAL_RESOLUTION'(MID_I + SYMBOL_SEPERATION);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);
    localparam int WB_W  = $clog2(WINDOW + 1);
    localparam int WE_W  = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {SEEK, HUNT, LOCKED} state_t;

    state_t             state_q, state_n;
    logic [30:0]        hist_q, hist_n, lfsr_q, lfsr_n;
    logic [4:0]         seek_q, seek_n;
    logic [RUN_W-1:0]   run_q, run_n;
    logic [WB_W-1:0]    wbits_q, wbits_n;
    logic [WE_W-1:0]    werrs_q, werrs_n;
    logic [1:0]         err_n, nbits, nerr, gray;
    logic               chk_locked, rx, p, e;
    logic [COUNT_W:0]   bc_sum, ec_sum;

    // Stage 1: slicer with thresholds owned by the upper level, then Gray decode.
    always_comb begin
        gray = 2'b10;
        if (voltage_level_in < TH_LO)       gray = 2'b00;
        else if (voltage_level_in < TH_MID) gray = 2'b01;
        else if (voltage_level_in < TH_HI)  gray = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            symbol_out       <= '0;
            symbol_out_valid <= 1'b0;
        end else begin
            symbol_out_valid <= en && voltage_level_in_valid;
            if (en && voltage_level_in_valid) symbol_out <= gray;
        end
    end

    // Stage 2: the FSM steps once per bit, so a state change mid-pair applies to the second bit.
    always_comb begin
        state_n    = state_q;
        hist_n     = hist_q;
        lfsr_n     = lfsr_q;
        seek_n     = seek_q;
        run_n      = run_q;
        wbits_n    = wbits_q;
        werrs_n    = werrs_q;
        err_n      = '0;
        nbits      = '0;
        nerr       = '0;
        chk_locked = 1'b0;
        rx         = 1'b0;
        p          = 1'b0;
        e          = 1'b0;
        if (symbol_out_valid) begin
            for (int unsigned i = 0; i < 2; i++) begin
                rx = (i == 0) ? symbol_out[1] : symbol_out[0];
                case (state_n)
                    SEEK: begin
                        hist_n = {hist_n[29:0], rx};
                        if (seek_n == 5'd30) begin
                            seek_n  = '0;
                            state_n = HUNT;
                        end else begin
                            seek_n = seek_n + 5'd1;
                        end
                    end
                    HUNT: begin
                        p      = hist_n[30] ^ hist_n[27];
                        hist_n = {hist_n[29:0], rx};
                        if (rx != p) begin
                            run_n = '0;
                        end else begin
                            run_n = run_n + RUN_W'(1);
                            if (run_n == RUN_W'(LOCK_COUNT)) begin
                                state_n = LOCKED;
                                lfsr_n  = hist_n;
                                run_n   = '0;
                                wbits_n = '0;
                                werrs_n = '0;
                            end
                        end
                    end
                    LOCKED: begin
                        p          = lfsr_n[30] ^ lfsr_n[27];
                        lfsr_n     = {lfsr_n[29:0], p};
                        e          = rx ^ p;
                        chk_locked = 1'b1;
                        if (i == 0) err_n[1] = e;
                        else        err_n[0] = e;
                        nbits   = nbits + 2'd1;
                        nerr    = nerr + {1'b0, e};
                        wbits_n = wbits_n + WB_W'(1);
                        werrs_n = werrs_n + WE_W'(e);
                        if (werrs_n == WE_W'(UNLOCK_ERRS)) begin
                            state_n = SEEK;
                            hist_n  = '0;
                            seek_n  = '0;
                            run_n   = '0;
                            wbits_n = '0;
                            werrs_n = '0;
                        end else if (wbits_n == WB_W'(WINDOW)) begin
                            wbits_n = '0;
                            werrs_n = '0;
                        end
                    end
                    default: state_n = SEEK;
                endcase
            end
        end
    end

    assign bc_sum = (COUNT_W+1)'(bit_count) + (COUNT_W+1)'(nbits);
    assign ec_sum = (COUNT_W+1)'(error_count) + (COUNT_W+1)'(nerr);
    assign locked = (state_q == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= SEEK;
            hist_q          <= '0;
            lfsr_q          <= '0;
            seek_q          <= '0;
            run_q           <= '0;
            wbits_q         <= '0;
            werrs_q         <= '0;
            error_out       <= '0;
            error_out_valid <= 1'b0;
            bit_count       <= '0;
            error_count     <= '0;
        end else begin
            state_q         <= state_n;
            hist_q          <= hist_n;
            lfsr_q          <= lfsr_n;
            seek_q          <= seek_n;
            run_q           <= run_n;
            wbits_q         <= wbits_n;
            werrs_q         <= werrs_n;
            error_out_valid <= chk_locked;
            if (chk_locked) error_out <= err_n;
            if (clear_counts) begin
                bit_count   <= '0;
                error_count <= '0;
            end else begin
                bit_count   <= bc_sum[COUNT_W] ? '1 : bc_sum[COUNT_W-1:0];
                error_count <= ec_sum[COUNT_W] ? '1 : ec_sum[COUNT_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_pam4_rx_checker.sv
// Scoreboard bench: the driver streams a PRBS31/Gray/PAM-4 signal with planned faults and
// queues the expected symbols and error records; a monitor pops and compares them.
module tb_pam4_rx_checker;
    logic        clk = 1'b0;
    logic        rst, en, vin_valid, clear_counts;
    logic [7:0]  vin;
    logic [1:0]  symbol_out, error_out, symbol_out2, error_out2;
    logic        symbol_out_valid, locked, error_out_valid;
    logic        symbol_out_valid2, locked2, error_out_valid2;
    logic [31:0] bit_count, error_count;
    logic [3:0]  bit_count2, error_count2;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] bc;
        logic [31:0] ec;
        logic        lk;
    } rec_t;

    logic [1:0] sym_q[$];
    rec_t       rec_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [7:0] volt [4] = '{8'd44, 8'd100, 8'd156, 8'd212};
    logic [7:0] bnd_v [6] = '{8'd71, 8'd72, 8'd127, 8'd128, 8'd183, 8'd184};
    logic [1:0] bnd_s [6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10};

    always #5 clk = ~clk;

    pam4_rx_checker #(.SIGNAL_RESOLUTION(8), .SYMBOL_SEPERATION(56), .LOCK_COUNT(64),
                      .WINDOW(128), .UNLOCK_ERRS(16), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .voltage_level_in(vin),
        .voltage_level_in_valid(vin_valid), .clear_counts(clear_counts),
        .symbol_out(symbol_out), .symbol_out_valid(symbol_out_valid), .locked(locked),
        .error_out(error_out), .error_out_valid(error_out_valid),
        .bit_count(bit_count), .error_count(error_count));

    pam4_rx_checker #(.COUNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .voltage_level_in(vin),
        .voltage_level_in_valid(vin_valid), .clear_counts(clear_counts),
        .symbol_out(symbol_out2), .symbol_out_valid(symbol_out_valid2), .locked(locked2),
        .error_out(error_out2), .error_out_valid(error_out_valid2),
        .bit_count(bit_count2), .error_count(error_count2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx2gray(input logic [1:0] i);
        case (i)
            2'd0:    return 2'b00;
            2'd1:    return 2'b01;
            2'd2:    return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] gray2idx(input logic [1:0] g);
        case (g)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Monitor: every valid output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (symbol_out_valid) begin
            if (sym_q.size() == 0) begin
                total++; bad++;
                $display("FAIL symbol_unexpected: got %0d want none", symbol_out);
            end else begin
                logic [1:0] es;
                es = sym_q.pop_front();
                check("symbol", 32'(symbol_out), 32'(es));
            end
        end
        if (error_out_valid) begin
            if (rec_q.size() == 0) begin
                total++; bad++;
                $display("FAIL errrec_unexpected: got err=%0d bc=%0d want none", error_out, bit_count);
            end else begin
                rec_t r;
                r = rec_q.pop_front();
                check("error_out", 32'(error_out), 32'(r.err));
                check("bit_count", bit_count, r.bc);
                check("error_count", error_count, r.ec);
                check("locked_at_rec", 32'(locked), 32'(r.lk));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_symbol_out"}, 32'(symbol_out), 32'd0);
        check({tag, "_symbol_valid"}, 32'(symbol_out_valid), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_error_out"}, 32'(error_out), 32'd0);
        check({tag, "_error_valid"}, 32'(error_out_valid), 32'd0);
        check({tag, "_bit_count"}, bit_count, 32'd0);
        check({tag, "_error_count"}, error_count, 32'd0);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 10 && (sym_q.size() + rec_q.size()) != 0; c++) @(negedge clk);
        check({tag, "_queue_left"}, 32'(sym_q.size() + rec_q.size()), 32'd0);
    endtask

    initial begin
        logic [30:0] g;
        logic [31:0] bc, ec;
        logic [1:0]  pr, idx, sent, er;
        logic        b1, b0, inj;
        int          nb;

        rst = 1'b1; en = 1'b0; vin_valid = 1'b0; vin = '0; clear_counts = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        g  = 31'h1234_5678;
        bc = '0;
        ec = '0;
        for (int k = 1; k <= 230; k++) begin
            if (k == 100) begin
                repeat (3) begin
                    @(negedge clk);
                    en = 1'b0; vin_valid = 1'b1; vin = 8'($urandom); clear_counts = 1'b0;
                end
            end
            @(negedge clk);
            if (k == 100) begin
                check("idle_symbol_valid", 32'(symbol_out_valid), 32'd0);
                check("idle_error_valid", 32'(error_out_valid), 32'd0);
            end
            if (k == 170) begin
                check("sat_bit_count", 32'(bit_count2), 32'd15);
                check("sat_error_count", 32'(error_count2), 32'd15);
                check("relock_pending", 32'(locked), 32'd0);
            end
            b1  = g[30] ^ g[27];
            g   = {g[29:0], b1};
            b0  = g[30] ^ g[27];
            g   = {g[29:0], b0};
            pr  = {b1, b0};
            idx = gray2idx(pr);
            inj = (k == 60) || (k >= 120 && k <= 135) || (k == 201);
            // Flipping the level LSB moves to the adjacent level and corrupts only bit[0].
            sent = inj ? (idx ^ 2'd1) : idx;
            sym_q.push_back(idx2gray(sent));
            if ((k >= 48 && k <= 135) || k >= 183) begin
                nb = (k == 48 || k == 183) ? 1 : 2;
                er = inj ? 2'b01 : 2'b00;
                if (k == 201) begin
                    bc = '0;
                    ec = '0;
                end else begin
                    bc = bc + 32'(nb);
                    ec = ec + 32'(er[0]);
                end
                rec_q.push_back('{err: er, bc: bc, ec: ec, lk: (k != 135)});
            end
            en = 1'b1; vin_valid = 1'b1; vin = volt[sent]; clear_counts = (k == 202);
        end
        @(negedge clk);
        vin_valid = 1'b0; clear_counts = 1'b0;
        drain("stream");
        check("final_locked", 32'(locked), 32'd1);
        check("final_sat_bit_count", 32'(bit_count2), 32'd15);
        check("final_sat_error_count", 32'(error_count2), 32'd0);

        @(negedge clk);
        rst = 1'b1; en = 1'b1; vin_valid = 1'b1; vin = 8'd200;
        @(negedge clk);
        check("rst_locked_next", 32'(locked), 32'd0);
        vin = 8'($urandom);
        @(negedge clk);
        vin = 8'($urandom);
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0; vin_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = 1'b1; vin_valid = 1'b1; vin = bnd_v[i];
            sym_q.push_back(bnd_s[i]);
        end
        @(negedge clk);
        vin_valid = 1'b0;
        drain("bounds");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
